// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t : fetch controller states
//   NOP_INSTR     : instruction word placed in IF/ID when it is flushed or reset
//   PC_STEP       : default sequential PC increment in bytes
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding at pc_value_i
        HOLD  = 2'd1,   // fetched word parked while ID is stalled
        DRAIN = 2'd2    // redirect seen mid-request; waiting out the stale ack
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: instruction word, its PC+4 and a valid bit.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   load                    : capture next_instr/next_pc_plus4 and mark valid
//   flush                   : clear to NOP / invalid (wins over load)
//   next_instr, next_pc_plus4 : data to capture on load
//   instr, pc_plus4, valid  : registered IF/ID contents
// With neither load nor flush the register holds, which is how ID stalls
// are absorbed.
module if_id_register
    import fetch_pkg::*;
#(
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              flush,
    input  logic [N_BITS-1:0] next_instr,
    input  logic [N_BITS-1:0] next_pc_plus4,
    output logic [N_BITS-1:0] instr,
    output logic [N_BITS-1:0] pc_plus4,
    output logic              valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr    <= N_BITS'(NOP_INSTR);
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr    <= N_BITS'(NOP_INSTR);
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= next_instr;
            pc_plus4 <= next_pc_plus4;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage between the PC register and ID.
// Issues a req/ack instruction-memory request at the current PC, loads the
// IF/ID register, and produces the PC register's next value and hold control
// so the PC only advances when the memory has answered.  Taken branches and
// jumps from ID redirect fetch and flush the wrong-path instruction.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   pc_value_i                      : current PC register value
//   new_pc_o, pc_hold_o             : next PC and PC-register hold (1 = keep)
//   imem_req_o, imem_addr_o         : memory request and its address
//   imem_ack_i, imem_rdata_i        : memory completion and instruction word
//   id_stall_i                      : ID cannot accept an instruction
//   branch_taken_i/branch_target_i  : ID redirect (taken branch, wins)
//   jump_i/jump_target_i            : ID redirect (j/jal/jr)
//   if_id_instr_o/_pc_plus4_o/_valid_o : IF/ID register contents
module fetch_stage #(
    parameter int unsigned        N_BITS   = 32,
    parameter logic [N_BITS-1:0]  RESET_PC = 32'h0040_0000,
    parameter int unsigned        PC_STEP  = fetch_pkg::PC_STEP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] pc_value_i,
    output logic [N_BITS-1:0] new_pc_o,
    output logic              pc_hold_o,
    output logic              imem_req_o,
    output logic [N_BITS-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [N_BITS-1:0] imem_rdata_i,
    input  logic              id_stall_i,
    input  logic              branch_taken_i,
    input  logic [N_BITS-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [N_BITS-1:0] jump_target_i,
    output logic [N_BITS-1:0] if_id_instr_o,
    output logic [N_BITS-1:0] if_id_pc_plus4_o,
    output logic              if_id_valid_o
);

    import fetch_pkg::*;

    // RESET_PC is owned by the PC register; it only has to be word aligned.
    if ((RESET_PC % PC_STEP) != 0) begin : g_reset_pc_check
        $error("RESET_PC is not aligned to PC_STEP");
    end

    fetch_state_t      state_reg, state_next;
    logic [N_BITS-1:0] buf_instr_reg, buf_pc_plus4_reg;
    logic [N_BITS-1:0] redir_pc_reg;

    logic              redirect;
    logic [N_BITS-1:0] pc_plus4;
    logic [N_BITS-1:0] target;

    logic              req_next;
    logic              buf_load, redir_load;
    logic              ifid_load, ifid_flush, ifid_sel_buf;
    logic [N_BITS-1:0] ifid_instr_in, ifid_pc_plus4_in;

    // Next-PC mux; the branch target wins when both redirects are raised.
    // The add wraps modulo 2^N_BITS.
    assign redirect = branch_taken_i | jump_i;
    assign pc_plus4 = pc_value_i + N_BITS'(PC_STEP);
    assign target   = branch_taken_i ? branch_target_i :
                      jump_i         ? jump_target_i   : pc_plus4;

    assign imem_addr_o = pc_value_i;
    // Reset kills the request combinationally; memory tolerates the abandoned one.
    assign imem_req_o  = req_next & ~reset;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: redirect > id_stall_i > ack
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH: begin
                if (redirect) begin
                    if (!imem_ack_i) state_next = DRAIN;
                end else if (imem_ack_i && id_stall_i) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (redirect || !id_stall_i) state_next = FETCH;
            end
            DRAIN: begin
                if (imem_ack_i) state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // Output / control logic
    always_comb begin
        req_next     = 1'b0;
        pc_hold_o    = 1'b1;
        new_pc_o     = target;
        buf_load     = 1'b0;
        redir_load   = 1'b0;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        ifid_sel_buf = 1'b0;
        case (state_reg)
            FETCH: begin
                req_next  = 1'b1;
                // The PC moves exactly when the word arrives, redirect or not,
                // which keeps imem_addr_o stable across an unacked request.
                pc_hold_o = ~imem_ack_i;
                if (redirect) begin
                    ifid_flush = 1'b1;
                    redir_load = ~imem_ack_i;
                end else if (imem_ack_i) begin
                    if (id_stall_i) buf_load  = 1'b1;
                    else            ifid_load = 1'b1;
                end
            end
            HOLD: begin
                // The PC already advanced when the buffered word was acked.
                if (redirect) begin
                    pc_hold_o  = 1'b0;
                    ifid_flush = 1'b1;
                end else if (!id_stall_i) begin
                    ifid_load    = 1'b1;
                    ifid_sel_buf = 1'b1;
                end
            end
            DRAIN: begin
                // Old request still in flight at the held PC; its data is dropped.
                req_next  = 1'b1;
                new_pc_o  = redir_pc_reg;
                pc_hold_o = ~imem_ack_i;
            end
            default: ;
        endcase
    end

    // Hold buffer and pending redirect target
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_instr_reg    <= '0;
            buf_pc_plus4_reg <= '0;
            redir_pc_reg     <= '0;
        end else begin
            if (buf_load) begin
                buf_instr_reg    <= imem_rdata_i;
                buf_pc_plus4_reg <= pc_plus4;
            end
            if (redir_load) begin
                redir_pc_reg <= target;
            end
        end
    end

    assign ifid_instr_in    = ifid_sel_buf ? buf_instr_reg    : imem_rdata_i;
    assign ifid_pc_plus4_in = ifid_sel_buf ? buf_pc_plus4_reg : pc_plus4;

    if_id_register #(
        .N_BITS (N_BITS)
    ) u_if_id (
        .clk           (clk),
        .reset         (reset),
        .load          (ifid_load),
        .flush         (ifid_flush),
        .next_instr    (ifid_instr_in),
        .next_pc_plus4 (ifid_pc_plus4_in),
        .instr         (if_id_instr_o),
        .pc_plus4      (if_id_pc_plus4_o),
        .valid         (if_id_valid_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a PC register and a word memory around the DUT,
// directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a queue-based reference model.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_value;
    logic [31:0] new_pc, imem_addr, imem_rdata;
    logic        hold, req;
    logic        ack = 1'b0, stall = 1'b0, br = 1'b0, jp = 1'b0;
    logic [31:0] bt = '0, jt = '0;
    logic [31:0] instr, pc4;
    logic        valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(.N_BITS(32), .RESET_PC(RPC), .PC_STEP(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_value_i       (pc_value),
        .new_pc_o         (new_pc),
        .pc_hold_o        (hold),
        .imem_req_o       (req),
        .imem_addr_o      (imem_addr),
        .imem_ack_i       (ack),
        .imem_rdata_i     (imem_rdata),
        .id_stall_i       (stall),
        .branch_taken_i   (br),
        .branch_target_i  (bt),
        .jump_i           (jp),
        .jump_target_i    (jt),
        .if_id_instr_o    (instr),
        .if_id_pc_plus4_o (pc4),
        .if_id_valid_o    (valid)
    );

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction
    assign imem_rdata = mem_word(imem_addr);

    // PC register in the environment
    always @(posedge clk or posedge reset) begin
        if (reset)      pc_value <= RPC;
        else if (!hold) pc_value <= new_pc;
    end

    // ---------------- reference model ----------------
    // held_*: word fetched while ID was stalled (at most one entry)
    // redir_q: redirect target waiting for a stale request to complete
    logic [31:0] held_instr_q[$];
    logic [31:0] held_pc4_q[$];
    logic [31:0] redir_q[$];
    logic [31:0] exp_instr = '0, exp_pc4 = '0;
    logic        exp_valid = 1'b0;

    function automatic logic [31:0] redirect_target();
        return br ? bt : jt;
    endfunction

    function automatic logic model_req();
        return !reset && (held_instr_q.size() == 0);
    endfunction

    function automatic logic [31:0] model_new_pc();
        if (redir_q.size() != 0) return redir_q[0];
        if (br || jp)            return redirect_target();
        return pc_value + 32'd4;
    endfunction

    function automatic logic model_hold();
        if (redir_q.size() != 0)      return !ack;
        if (held_instr_q.size() != 0) return !(br || jp);
        return !ack;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            held_instr_q.delete();
            held_pc4_q.delete();
            redir_q.delete();
            exp_instr <= '0;
            exp_pc4   <= '0;
            exp_valid <= 1'b0;
        end else if (redir_q.size() != 0) begin
            if (ack) redir_q.delete();
        end else if (held_instr_q.size() != 0) begin
            if (br || jp) begin
                held_instr_q.delete();
                held_pc4_q.delete();
                exp_instr <= '0; exp_pc4 <= '0; exp_valid <= 1'b0;
            end else if (!stall) begin
                exp_instr <= held_instr_q[0];
                exp_pc4   <= held_pc4_q[0];
                exp_valid <= 1'b1;
                held_instr_q.delete();
                held_pc4_q.delete();
            end
        end else begin
            if (br || jp) begin
                exp_instr <= '0; exp_pc4 <= '0; exp_valid <= 1'b0;
                if (!ack) redir_q.push_back(redirect_target());
            end else if (ack) begin
                if (stall) begin
                    held_instr_q.push_back(imem_rdata);
                    held_pc4_q.push_back(pc_value + 32'd4);
                end else begin
                    exp_instr <= imem_rdata;
                    exp_pc4   <= pc_value + 32'd4;
                    exp_valid <= 1'b1;
                end
            end
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("req",       {31'b0, req},   {31'b0, model_req()});
        check("addr",      imem_addr,      pc_value);
        check("new_pc",    new_pc,         model_new_pc());
        check("pc_hold",   {31'b0, hold},  {31'b0, model_hold()});
        check("ifid_instr", instr,         exp_instr);
        check("ifid_pc4",   pc4,           exp_pc4);
        check("ifid_valid", {31'b0, valid}, {31'b0, exp_valid});
    end

    // ---------------- stimulus ----------------
    task automatic cycle(input logic a, input logic s, input logic b, input logic [31:0] bt_v,
                         input logic j, input logic [31:0] jt_v);
        @(posedge clk);
        #1;
        stall = s; br = b; bt = bt_v; jp = j; jt = jt_v;
        ack = a & req;
    endtask

    task automatic idle(input logic a);
        cycle(a, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1; ack = 1'b0; stall = 1'b0; br = 1'b0; jp = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check("rst_req",   {31'b0, req},   32'd1);
        check("rst_hold",  {31'b0, hold},  32'd1);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_instr", instr,          32'd0);
    endtask

    // Raise reset in the middle of the current cycle and release it next cycle.
    task automatic mid_reset(input string tag);
        #2;
        reset = 1'b1; ack = 1'b0;
        #1;
        check({tag, "_req"},   {31'b0, req},   32'd0);
        check({tag, "_valid"}, {31'b0, valid}, 32'd0);
        check({tag, "_instr"}, instr,          32'd0);
        check({tag, "_pc4"},   pc4,            32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check({tag, "_resume"}, {31'b0, req}, 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Sequential fetch with immediate ack
        do_reset();
        idle(1'b1); #2;
        check("seq_new_pc", new_pc, 32'h0040_0004);
        check("seq_hold", {31'b0, hold}, 32'd0);
        idle(1'b0); #2;
        check("seq_valid", {31'b0, valid}, 32'd1);
        check("seq_pc4", pc4, 32'h0040_0004);
        check("seq_instr", instr, mem_word(32'h0040_0000));

        // Ack three cycles after the request
        for (int i = 0; i < 2; i++) begin
            idle(1'b0); #2;
            check("lat_hold", {31'b0, hold}, 32'd1);
            check("lat_addr", imem_addr, 32'h0040_0004);
        end
        idle(1'b1); #2;
        check("lat_ack_hold", {31'b0, hold}, 32'd0);
        idle(1'b0); #2;
        check("lat_pc4", pc4, 32'h0040_0008);
        idle(1'b0); #2;
        check("lat_once", pc4, 32'h0040_0008);

        // ID stall while the word arrives
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0); #2;
            check("stall_req", {31'b0, req}, 32'd0);
            check("stall_valid", {31'b0, valid}, 32'd0);
        end
        idle(1'b0);
        idle(1'b0); #2;
        check("stall_rel_valid", {31'b0, valid}, 32'd1);
        check("stall_rel_pc4", pc4, 32'h0040_0004);
        check("stall_rel_instr", instr, mem_word(32'h0040_0000));
        check("stall_next_addr", imem_addr, 32'h0040_0004);
        check("stall_next_pc", new_pc, 32'h0040_0008);

        // Branch while a request is unacked
        do_reset();
        cycle(1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b0, 32'h0); #2;
        check("drain_enter_hold", {31'b0, hold}, 32'd1);
        idle(1'b0); #2;
        check("drain_addr", imem_addr, 32'h0040_0000);
        check("drain_new_pc", new_pc, 32'h0040_0100);
        check("drain_req", {31'b0, req}, 32'd1);
        idle(1'b1); #2;
        check("drain_ack_hold", {31'b0, hold}, 32'd0);
        idle(1'b0); #2;
        check("drain_pc", imem_addr, 32'h0040_0100);
        check("drain_valid", {31'b0, valid}, 32'd0);

        // Both redirects, then sequential wrap
        do_reset();
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200); #2;
        check("both_new_pc", new_pc, 32'h0000_0100);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC); #2;
        check("jump_new_pc", new_pc, 32'hFFFF_FFFC);
        idle(1'b1); #2;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_new_pc", new_pc, 32'h0000_0000);

        // Reset in HOLD
        do_reset();
        idle(1'b1);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        mid_reset("rst_hold");

        // Reset in DRAIN
        cycle(1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
        idle(1'b0);
        mid_reset("rst_drain");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 9) < 3),
                      1'($urandom_range(0, 9) == 0), $urandom() & 32'hFFFF_FFFC,
                      1'($urandom_range(0, 9) == 0), $urandom() & 32'hFFFF_FFFC);
            end
        end

        idle(1'b0);
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
